// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-stage access path.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables/replicated data, load extraction
// and sign/zero extension, plus misalignment / illegal-size detection. Zero latency.
module load_store_align
  import mem_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [1:0]  off;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign off   = addr[1:0];
  assign rbyte = rdata[{off, 3'b000} +: 8];
  assign rhalf = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    be    = BE_W;
    wdata = '0;
    fault = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be    = BE_B << off;
          wdata = {4{rs2[7:0]}};
        end
        F3_H: begin
          be    = BE_H << off;
          wdata = {2{rs2[15:0]}};
          fault = addr[0];
        end
        F3_W: begin
          wdata = rs2;
          fault = (off != 2'b00);
        end
        default: fault = 1'b1;
      endcase
    end else if (is_load) begin
      case (funct3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = addr[0];
        F3_W:        fault = (off != 2'b00);
        default:     fault = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
      F3_BU:   load_data = {24'h000000, rbyte};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_data = {16'h0000, rhalf};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: IDLE -> REQ (until ack or TIMEOUT) -> DONE, min 3 cycles;
// holds the pipeline via mem_stall while an access is pending, faults are flagged without a bus cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_rs2_data,
  input  logic [2:0]  EX_MEM_funct3,
  output logic [31:0] memread_data,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        mem_timeout,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          access;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_load;
  logic          al_fault;

  assign access = EX_MEM_MemRead | EX_MEM_MemWrite;

  load_store_align u_align (
    .is_load   (EX_MEM_MemRead),
    .is_store  (EX_MEM_MemWrite),
    .funct3    (EX_MEM_funct3),
    .addr      (EX_MEM_alu_result),
    .rs2       (EX_MEM_rs2_data),
    .rdata     (dm_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load),
    .fault     (al_fault)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    mem_stall = 1'b0;
    mem_fault = 1'b0;

    case (state_q)
      IDLE: begin
        rdata_d   = '0;
        timeout_d = 1'b0;
        if (access) begin
          if (al_fault) begin
            mem_fault = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_d   = REQ;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = EX_MEM_MemWrite;
            addr_d    = {EX_MEM_alu_result[31:2], 2'b00};
            be_d      = al_be;
            wdata_d   = al_wdata;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        // EX/MEM is frozen during REQ, so the aligner still sees this access's funct3/addr.
        if (dm_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : al_load;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        rdata_d   = '0;
        timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_stall = 1'b0;
      mem_fault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign memread_data = rdata_q;
  assign mem_timeout  = timeout_q;
  assign dm_req       = req_q;
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_be        = be_q;
  assign dm_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected load results.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam int BOUND = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] alu, rs2_data;
  logic [2:0]  funct3;
  logic [31:0] memread_data;
  logic        mem_stall, mem_fault, mem_timeout;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_MemRead    (MemRead),
    .EX_MEM_MemWrite   (MemWrite),
    .EX_MEM_alu_result (alu),
    .EX_MEM_rs2_data   (rs2_data),
    .EX_MEM_funct3     (funct3),
    .memread_data      (memread_data),
    .mem_stall         (mem_stall),
    .mem_fault         (mem_fault),
    .mem_timeout       (mem_timeout),
    .dm_req            (dm_req),
    .dm_we             (dm_we),
    .dm_addr           (dm_addr),
    .dm_be             (dm_be),
    .dm_wdata          (dm_wdata),
    .dm_ack            (dm_ack),
    .dm_rdata          (dm_rdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    if (!wr) return 4'b1111;
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {4{v[7:0]}};
      3'b001:  return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  // ack_wait < 0 means the bus never acknowledges.
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] rs2, input int ack_wait,
                        input logic [31:0] rdata);
    exp_t e;
    exp_t got_e;
    int   stalls, reqs, cyc, req_windows;
    e.tmo  = (ack_wait < 0) || (ack_wait >= TO);
    e.data = (wr || e.tmo) ? 32'h0 : m_load(f3, addr[1:0], rdata);
    sb.push_back(e);
    req_windows = e.tmo ? TO : ack_wait + 1;

    MemRead  = !wr;
    MemWrite = wr;
    alu      = addr;
    rs2_data = rs2;
    funct3   = f3;
    #1;
    chk({tag, " idle_stall"}, mem_stall, 1);
    chk({tag, " idle_fault"}, mem_fault, 0);
    stalls = 1;
    reqs   = 0;
    cyc    = 0;
    tick;
    chk({tag, " req"}, dm_req, 1);
    chk({tag, " we"}, dm_we, wr);
    chk({tag, " addr"}, dm_addr, {addr[31:2], 2'b00});
    chk({tag, " be"}, dm_be, m_be(wr, f3, addr[1:0]));
    if (wr) chk({tag, " wdata"}, dm_wdata, m_wdata(f3, rs2));

    while (mem_stall === 1'b1 && cyc < BOUND) begin
      stalls++;
      if (dm_req === 1'b1) reqs++;
      if (ack_wait >= 0 && cyc == ack_wait) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end else begin
        dm_ack   = 1'b0;
        dm_rdata = $urandom;
      end
      cyc++;
      tick;
    end
    dm_ack = 1'b0;

    chk({tag, " within_bound"}, (cyc < BOUND), 1);
    chk({tag, " stall_cycles"}, stalls, 1 + req_windows);
    chk({tag, " req_cycles"}, reqs, req_windows);
    chk({tag, " done_req_low"}, dm_req, 0);
    chk({tag, " done_addr_held"}, dm_addr, {addr[31:2], 2'b00});
    if (sb.size() == 0) begin
      chk({tag, " sb_nonempty"}, 0, 1);
    end else begin
      got_e = sb.pop_front();
      chk({tag, " data"}, memread_data, got_e.data);
      chk({tag, " timeout"}, mem_timeout, got_e.tmo);
    end

    MemRead  = 1'b0;
    MemWrite = 1'b0;
    tick;
    chk({tag, " idle_data_clr"}, memread_data, 0);
    chk({tag, " idle_tmo_clr"}, mem_timeout, 0);
  endtask

  task automatic fault_case(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [2:0] f3);
    MemRead  = !wr;
    MemWrite = wr;
    alu      = addr;
    rs2_data = 32'hA5A5_5A5A;
    funct3   = f3;
    #1;
    chk({tag, " fault"}, mem_fault, 1);
    chk({tag, " stall"}, mem_stall, 0);
    chk({tag, " data"}, memread_data, 0);
    tick;
    chk({tag, " no_req"}, dm_req, 0);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    chk({tag, " fault_1cyc"}, mem_fault, 0);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    alu      = 32'h100;
    rs2_data = 32'h0;
    funct3   = 3'b010;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;

    // Reset state, with a legal load presented to show stall stays low under reset.
    tick;
    chk("rst stall", mem_stall, 0);
    chk("rst fault", mem_fault, 0);
    chk("rst req", dm_req, 0);
    chk("rst we", dm_we, 0);
    chk("rst addr", dm_addr, 0);
    chk("rst be", dm_be, 0);
    chk("rst wdata", dm_wdata, 0);
    chk("rst data", memread_data, 0);
    chk("rst tmo", mem_timeout, 0);
    MemRead = 1'b0;
    rst     = 1'b0;
    tick;

    access("lw100", 1'b0, 32'h100, 3'b010, 32'h0, 0, 32'hDEADBEEF);
    access("lb203", 1'b0, 32'h203, 3'b000, 32'h0, 0, 32'h80FF_FF7F);
    access("lbu203", 1'b0, 32'h203, 3'b100, 32'h0, 0, 32'h80FF_FF7F);
    access("lh202", 1'b0, 32'h202, 3'b001, 32'h0, 1, 32'h80FF_FF7F);
    access("lhu202", 1'b0, 32'h202, 3'b101, 32'h0, 2, 32'h80FF_1234);
    access("sb301", 1'b1, 32'h301, 3'b000, 32'h12345678, 0, 32'hFFFF_FFFF);
    access("sh302", 1'b1, 32'h302, 3'b001, 32'hCAFEBABE, 1, 32'h0);
    access("sw304_lastcyc", 1'b1, 32'h304, 3'b010, 32'h0BAD_F00D, TO - 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] f;
      f = i[0] ? 3'b100 : 3'b000;
      access("lb_loop", 1'b0, 32'h700 + i, f, 32'h0, int'($urandom_range(0, 2)), $urandom);
    end

    fault_case("lw102_misalign", 1'b0, 32'h102, 3'b010);
    fault_case("sw_f3_011", 1'b1, 32'h100, 3'b011);
    fault_case("lh201_misalign", 1'b0, 32'h201, 3'b001);
    fault_case("ld_f3_110", 1'b0, 32'h100, 3'b110);

    access("lw400_timeout", 1'b0, 32'h400, 3'b010, 32'h0, -1, 32'h0);
    // Stray ack with nothing in flight.
    dm_ack   = 1'b1;
    dm_rdata = 32'h1234_5678;
    #1;
    chk("stray stall", mem_stall, 0);
    tick;
    tick;
    chk("stray req", dm_req, 0);
    chk("stray data", memread_data, 0);
    chk("stray tmo", mem_timeout, 0);
    dm_ack = 1'b0;
    access("lw_after_timeout", 1'b0, 32'h404, 3'b010, 32'h0, 0, 32'h0102_0304);

    // Reset during the second REQ cycle discards the in-flight access.
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    alu      = 32'h500;
    funct3   = 3'b010;
    tick;
    tick;
    chk("midrst req_before", dm_req, 1);
    rst = 1'b1;
    #1;
    chk("midrst stall", mem_stall, 0);
    tick;
    rst     = 1'b0;
    MemRead = 1'b0;
    #1;
    chk("midrst req", dm_req, 0);
    chk("midrst addr", dm_addr, 0);
    chk("midrst be", dm_be, 0);
    chk("midrst we", dm_we, 0);
    chk("midrst wdata", dm_wdata, 0);
    chk("midrst data", memread_data, 0);
    chk("midrst tmo", mem_timeout, 0);
    chk("midrst idle_stall", mem_stall, 0);
    tick;
    access("lw_after_rst", 1'b0, 32'h600, 3'b010, 32'h0, 1, 32'hC0FF_EE11);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
